shrimp_fetch_stage: RTL and testbench
=====================================

// Module: shrimp_fetch_stage
// PURPOSE
//  Fetch stage directly downstream of shrimp_instruction_counter. Presents the
//  counter's instruction_address to a 1-cycle synchronous instruction memory.
//  Tags each fetch as live/squashed and delivers {instr, instr_pc, instr_valid}
//  to decode. Squashes in-flight fetches on jump, traps misaligned addresses,
//  and stops fetching on a HALT opcode.
// PARAMETERS
//  ADDR_WIDTH   16       instruction address width (matches the counter)
//  INSTR_WIDTH  16       instruction word width
//  HALT_OPCODE  16'hFFFF instruction word that halts fetch
//  COUNT_WIDTH  16       width of fetch_count (wraps)
// PORTS
//  clock               in   1       single clock, all state on posedge
//  reset               in   1       asynchronous, active-low; 0 clears all state immediately
//  instruction_address in   ADDR    current PC from shrimp_instruction_counter
//  jump                in   1       same jump signal that drives the counter
//  mem_addr            out  ADDR    memory read address (= instruction_address, combinational)
//  mem_en              out  1       memory read enable
//  mem_rdata           in   INSTR   M[mem_addr of previous cycle], valid 1 cycle after mem_en
//  instr_valid         out  1       instr/instr_pc valid this cycle; no backpressure
//  instr               out  INSTR   fetched instruction word
//  instr_pc            out  ADDR    address of instr
//  halted              out  1       sticky: HALT_OPCODE delivered
//  fetch_fault         out  1       sticky: odd live address seen
//  fault_addr          out  ADDR    address that caused fetch_fault
//  fetch_count         out  COUNT   number of instr_valid pulses since reset (wraps)
// BEHAVIOUR
//  - Reset (reset=0): state=RUN; live_q, instr_valid, halted, fetch_fault = 0;
//    instr, instr_pc, addr_q, fault_addr, fetch_count = 0. Async assert, sync release.
//  - States: RUN, HALTED, FAULT. HALTED and FAULT are exited only by reset.
//  - mem_en = (state==RUN) && reset. mem_addr = instruction_address always.
//  - Stage 1, every edge: addr_q <= instruction_address.
//    live_q <= (state==RUN) && !jump && !instruction_address[0] && !halt_now.
//  - Stage 2, every edge: instr <= mem_rdata; instr_pc <= addr_q.
//    instr_valid <= live_q && !jump && (state==RUN) && !halt_now.
//  - Latency: address shown in cycle t -> instr_valid high after edge t+2.
//  - Jump asserted at edge k: clears live_q and instr_valid at that edge. Both
//    in-flight fetches are squashed. The first live fetch is the jump target
//    (counter value after edge k). It is delivered after edge k+2.
//    Back-to-back jumps: only the address after the last jump survives.
//  - Misaligned: an odd instruction_address in RUN with jump=0 at the edge sets
//    fetch_fault=1, fault_addr=address, and state->FAULT. It is never delivered.
//    An older live fetch still in stage 2 is delivered normally. An odd address
//    squashed by jump at the same edge raises no fault.
//  - Halt: halt_now = instr_valid && (instr==HALT_OPCODE) && state==RUN.
//    The HALT word itself is delivered (1 valid pulse). At the next edge:
//    halted=1, state->HALTED, and live_q and instr_valid are forced to 0.
//    In HALTED or FAULT: no further instr_valid, mem_en=0, jump ignored.
//  - fetch_count increments by 1 on each edge where instr_valid is set. It wraps
//    from 2^COUNT_WIDTH-1 to 0.
//  - The counter keeps advancing in HALTED/FAULT; this block ignores it.
//  - Reset mid-fetch: in-flight fetches are discarded. There is no valid pulse
//    until 2 edges after release.
// TESTING
//  - Reset release, counter 0,2,4.., M[a]=a+16'h100 -> instr_valid after
//    edge 2: (pc 0, 0x0100), then pc 2, 4 every cycle; fetch_count 1,2,3.
//  - Jump to 0x0040 while pc 6/8 in flight -> pcs 6 and 8 never valid. Next
//    valid is pc 0x0040 two edges after jump. No gap afterwards.
//  - Jumps on 2 consecutive edges (0x0040, then 0x0080) -> 0x0040 never
//    delivered. 0x0080 is valid 2 edges after the second jump.
//  - M[0x000A]=16'hFFFF -> pc 0x000A delivered once, then halted=1. Then
//    instr_valid=0 and mem_en=0 forever, including after jump.
//  - Jump to 0x0011 -> fetch_fault=1, fault_addr=0x0011, no valid for 0x0011,
//    mem_en=0. Odd address with jump at the same edge -> no fault.
//  - reset=0 mid-stream, async between edges -> all outputs 0 immediately.
//    After release, first valid is 2 edges later; fetch_count restarts at 1.

Source files
------------

// File: rtl/shrimp_fetch_stage.sv
// Purpose: two-stage fetch front-end between shrimp_instruction_counter and decode.
// Latency: address presented in cycle t is delivered on instr_valid after the second following edge.
// Backpressure: none; decode must accept every instr_valid pulse.
module shrimp_fetch_stage #(
    parameter int                     ADDR_WIDTH  = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = 16'hFFFF,
    parameter int                     COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  instruction_address,
    input  logic                   jump,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_en,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   halted,
    output logic                   fetch_fault,
    output logic [ADDR_WIDTH-1:0]  fault_addr,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    live_q;
    logic [ADDR_WIDTH-1:0]   addr_q;

    logic                    running;
    logic                    halt_now;
    logic                    misaligned;
    logic                    live_nxt;
    logic                    valid_nxt;

    assign running    = (state == RUN);
    assign halt_now   = instr_valid && (instr == HALT_OPCODE) && running;
    // A jump at the same edge squashes the odd address, so it cannot fault.
    assign misaligned = running && !jump && instruction_address[0] && !halt_now;
    assign live_nxt   = running && !jump && !instruction_address[0] && !halt_now;
    assign valid_nxt  = live_q && !jump && running && !halt_now;

    assign mem_addr = instruction_address;
    assign mem_en   = running && reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (halt_now) begin
                    state_nxt = HALTED;
                end else if (misaligned) begin
                    state_nxt = FAULT;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    // Stage 1: address/liveness tag, aligned with the memory read in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            live_q <= 1'b0;
        end else begin
            addr_q <= instruction_address;
            live_q <= live_nxt;
        end
    end

    // Stage 2: memory data joins its address; valid only if never squashed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            instr       <= mem_rdata;
            instr_pc    <= addr_q;
            instr_valid <= valid_nxt;
            fetch_count <= fetch_count + {{(COUNT_WIDTH-1){1'b0}}, valid_nxt};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halted      <= 1'b0;
            fetch_fault <= 1'b0;
            fault_addr  <= '0;
        end else begin
            if (halt_now) begin
                halted <= 1'b1;
            end
            if (misaligned) begin
                fetch_fault <= 1'b1;
                fault_addr  <= instruction_address;
            end
        end
    end

endmodule

// File: tb/tb_shrimp_fetch_stage.sv
// Scoreboard bench for shrimp_fetch_stage: a counter/memory model drives the DUT
// and expected deliveries are queued at stimulus time, then compared on output.
module tb_shrimp_fetch_stage;

    localparam int CW = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instruction_address;
    logic        jump;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        halted;
    logic        fetch_fault;
    logic [15:0] fault_addr;
    logic [CW-1:0] fetch_count;

    shrimp_fetch_stage #(
        .ADDR_WIDTH (16),
        .INSTR_WIDTH(16),
        .HALT_OPCODE(16'hFFFF),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .instruction_address(instruction_address),
        .jump               (jump),
        .mem_addr           (mem_addr),
        .mem_en             (mem_en),
        .mem_rdata          (mem_rdata),
        .instr_valid        (instr_valid),
        .instr              (instr),
        .instr_pc           (instr_pc),
        .halted             (halted),
        .fetch_fault        (fetch_fault),
        .fault_addr         (fault_addr),
        .fetch_count        (fetch_count)
    );

    always #5 clock = ~clock;

    logic halt_word_en = 1'b0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (halt_word_en && a == 16'h000A) return 16'hFFFF;
        return a + 16'h0100;
    endfunction

    // 1-cycle synchronous instruction memory
    always @(posedge clock) mem_rdata <= memf(mem_addr);

    typedef struct {
        logic [15:0] pc;
        logic [15:0] dat;
        int          due;
    } exp_t;

    localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;

    exp_t        sb[$];
    int          mstate;
    int          edge_no;
    logic [15:0] pc;
    logic [CW-1:0] exp_count;
    logic        halt_pend;
    logic        exp_fault;
    logic [15:0] exp_faddr;
    int          seen_cnt[logic [15:0]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        seen_cnt.delete();
        mstate    = M_RUN;
        exp_count = '0;
        halt_pend = 1'b0;
        exp_fault = 1'b0;
        exp_faddr = 16'h0;
        pc        = 16'h0;
    endtask

    // One counter cycle: present pc, step an edge, compare, then advance the counter.
    task automatic cycle(input logic j, input logic [15:0] tgt);
        exp_t e;
        instruction_address = pc;
        jump = j;
        #1;
        check("mem_addr", mem_addr, pc);
        @(posedge clock);
        #1;
        edge_no++;
        if (halt_pend) begin
            sb.delete();
            mstate    = M_HALT;
            halt_pend = 1'b0;
        end else if (mstate == M_RUN) begin
            if (j) begin
                sb.delete();
            end else if (pc[0]) begin
                mstate    = M_FAULT;
                exp_fault = 1'b1;
                exp_faddr = pc;
            end else begin
                sb.push_back('{pc: pc, dat: memf(pc), due: edge_no + 1});
            end
        end
        if (instr_valid === 1'b1) begin
            if (seen_cnt.exists(instr_pc)) seen_cnt[instr_pc]++;
            else seen_cnt[instr_pc] = 1;
        end
        if (sb.size() > 0 && sb[0].due == edge_no) begin
            e = sb.pop_front();
            check("instr_valid", {31'b0, instr_valid}, 32'd1);
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.dat);
            exp_count++;
            if (e.dat == 16'hFFFF) halt_pend = 1'b1;
        end else begin
            check("instr_valid_idle", {31'b0, instr_valid}, 32'd0);
        end
        check("fetch_count", fetch_count, exp_count);
        check("halted", {31'b0, halted}, {31'b0, mstate == M_HALT});
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
        check("fault_addr", fault_addr, exp_faddr);
        check("mem_en", {31'b0, mem_en}, {31'b0, mstate == M_RUN});
        pc = j ? tgt : pc + 16'd2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_pc"}, instr_pc, 32'd0);
        check({tag, "_count"}, fetch_count, 32'd0);
        check({tag, "_halted"}, {31'b0, halted}, 32'd0);
        check({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
        check({tag, "_faddr"}, fault_addr, 32'd0);
        check({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
    endtask

    // Asynchronous reset asserted between edges, held across one edge, released between edges.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        jump  = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clock);
        #1;
        edge_no++;
        check("rst_hold_valid", {31'b0, instr_valid}, 32'd0);
        #3;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset = 1'b0;
        jump = 1'b0;
        instruction_address = 16'h0;
        edge_no = 0;
        model_reset();
        #12;
        check_all_zero("por");
        reset = 1'b1;

        // Sequential fetch, then jump while pcs 6 and 8 are in flight.
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0);
        cycle(1'b1, 16'h0040);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0);
        check("pc6_squashed", {31'b0, seen_cnt.exists(16'h0006)}, 32'd0);
        check("pc8_squashed", {31'b0, seen_cnt.exists(16'h0008)}, 32'd0);
        check("pc40_delivered", {31'b0, seen_cnt.exists(16'h0040)}, 32'd1);

        // Back-to-back jumps: only the second target survives.
        cycle(1'b1, 16'h0100);
        cycle(1'b1, 16'h0200);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0);
        check("pc100_squashed", {31'b0, seen_cnt.exists(16'h0100)}, 32'd0);
        check("pc200_delivered", {31'b0, seen_cnt.exists(16'h0200)}, 32'd1);

        // Long run so the narrow fetch_count wraps through zero.
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0);

        // Reset mid-stream, then HALT word at 0x000A.
        do_reset();
        halt_word_en = 1'b1;
        for (int i = 0; i < 9; i++) cycle(1'b0, 16'h0);
        cycle(1'b1, 16'h0020);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0);
        check("halt_word_once", seen_cnt.exists(16'h000A) ? seen_cnt[16'h000A] : 0, 32'd1);
        check("halted_final", {31'b0, halted}, 32'd1);

        // Odd address squashed by a jump raises nothing; an unsquashed one faults.
        do_reset();
        halt_word_en = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0);
        cycle(1'b1, 16'h0021);
        cycle(1'b1, 16'h0030);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0);
        check("no_fault_squashed", {31'b0, fetch_fault}, 32'd0);
        cycle(1'b1, 16'h0011);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0);
        check("fault_final", {31'b0, fetch_fault}, 32'd1);
        check("fault_addr_final", fault_addr, 32'h0011);
        check("pc11_never", {31'b0, seen_cnt.exists(16'h0011)}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
